// File: rtl/dp_vector_player.sv
`default_nettype none
// ============================================================================
// Module      : dp_vector_player
// Description : Control-vector replay engine for the 16-bit datapath. Plays a
//               programmable table of control words one per cycle and checks
//               the observed SysBus against expected values after a fixed
//               pipeline latency, keeping sticky error status.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_vector_player #(
    parameter int CTRL_W  = 24,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 32,
    parameter int CHK_LAT = 1,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [CTRL_W-1:0] LdCtrl,
    input  logic [DATA_W-1:0] LdExp,
    input  logic              LdChk,
    input  logic              Start,
    input  logic              Stop,
    input  logic [ADDR_W-1:0] LastAddr,
    input  logic [7:0]        Loops,
    input  logic [DATA_W-1:0] Obs,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic              Busy,
    output logic              Done,
    output logic              ErrFlag,
    output logic [15:0]       ErrCount,
    output logic [ADDR_W-1:0] FirstErrAddr
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // DRAIN lasts CHK_LAT cycles; the counter runs down to zero.
    localparam logic [2:0] c_DRAIN_INIT = 3'(CHK_LAT - 1);

    // Vector table (never reset; contents survive Reset)
    logic [CTRL_W-1:0] r_ctrlMem [DEPTH];
    logic [DATA_W-1:0] r_expMem  [DEPTH];
    logic              r_chkMem  [DEPTH];

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_lastAddr;
    logic              r_loopsZero;
    logic [7:0]        r_passCnt;
    logic [2:0]        r_drainCnt;
    logic [CTRL_W-1:0] r_ctrlOut;
    logic              r_busy;
    logic              r_done;
    logic              r_errFlag;
    logic [15:0]       r_errCount;
    logic [ADDR_W-1:0] r_firstErrAddr;

    // Check pipeline: stage CHK_LAT-1 is the head compared against Obs
    logic [CHK_LAT-1:0] r_pipeChk;
    logic [DATA_W-1:0]  r_pipeExp  [CHK_LAT];
    logic [ADDR_W-1:0]  r_pipeAddr [CHK_LAT];

    logic [1:0]        w_stateNext;
    logic [ADDR_W-1:0] w_ptrNext;
    logic [7:0]        w_passNext;
    logic [2:0]        w_drainNext;
    logic [CTRL_W-1:0] w_ctrlNext;
    logic              w_busyNext;
    logic              w_doneNext;
    logic              w_push;
    logic              w_start;
    logic              w_mismatch;

    // Table writes are accepted only while idle
    always_ff @(posedge Clock) begin
        if (LdEn && (r_state == c_IDLE)) begin
            r_ctrlMem[LdAddr] <= LdCtrl;
            r_expMem[LdAddr]  <= LdExp;
            r_chkMem[LdAddr]  <= LdChk;
        end
    end

    // FSM state register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and next-output decode; outputs are registered below
    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_passNext  = r_passCnt;
        w_drainNext = r_drainCnt;
        w_ctrlNext  = '0;
        w_busyNext  = 1'b0;
        w_doneNext  = 1'b0;
        w_push      = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (Start) begin
                    w_stateNext = c_RUN;
                    w_ptrNext   = '0;
                    w_passNext  = Loops;
                    w_start     = 1'b1;
                end
            end
            c_RUN: begin
                w_ctrlNext = r_ctrlMem[r_ptr];
                w_busyNext = 1'b1;
                w_push     = 1'b1;
                w_ptrNext  = r_ptr + 1'b1;
                if (Stop) begin
                    w_stateNext = c_DRAIN;
                    w_drainNext = c_DRAIN_INIT;
                end else if (r_ptr == r_lastAddr) begin
                    if (!r_loopsZero && (r_passCnt == 8'd1)) begin
                        w_stateNext = c_DRAIN;
                        w_drainNext = c_DRAIN_INIT;
                    end else begin
                        // Wrap straight back to entry 0 with no bubble
                        w_ptrNext = '0;
                        if (!r_loopsZero) begin
                            w_passNext = r_passCnt - 8'd1;
                        end
                    end
                end
            end
            c_DRAIN: begin
                w_busyNext = 1'b1;
                if (r_drainCnt == 3'd0) begin
                    w_stateNext = c_DONE;
                end else begin
                    w_drainNext = r_drainCnt - 3'd1;
                end
            end
            c_DONE: begin
                w_doneNext  = 1'b1;
                w_stateNext = c_IDLE;
            end
            default: begin
                w_stateNext = c_IDLE;
            end
        endcase
    end

    // Playback counters, Start-time samples and registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ptr       <= '0;
            r_passCnt   <= '0;
            r_drainCnt  <= '0;
            r_lastAddr  <= '0;
            r_loopsZero <= 1'b0;
            r_ctrlOut   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_ptr      <= w_ptrNext;
            r_passCnt  <= w_passNext;
            r_drainCnt <= w_drainNext;
            r_ctrlOut  <= w_ctrlNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            if (w_start) begin
                r_lastAddr  <= LastAddr;
                r_loopsZero <= (Loops == 8'd0);
            end
        end
    end

    // Shift issued vectors towards the compare point
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_pipeChk <= '0;
            for (int i = 0; i < CHK_LAT; i++) begin
                r_pipeExp[i]  <= '0;
                r_pipeAddr[i] <= '0;
            end
        end else begin
            r_pipeChk[0]  <= w_push & r_chkMem[r_ptr];
            r_pipeExp[0]  <= r_expMem[r_ptr];
            r_pipeAddr[0] <= r_ptr;
            for (int i = 1; i < CHK_LAT; i++) begin
                r_pipeChk[i]  <= r_pipeChk[i-1];
                r_pipeExp[i]  <= r_pipeExp[i-1];
                r_pipeAddr[i] <= r_pipeAddr[i-1];
            end
        end
    end

    assign w_mismatch = r_pipeChk[CHK_LAT-1] && (Obs != r_pipeExp[CHK_LAT-1]);

    // Sticky error status; Start clears it for the new run
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_errFlag      <= 1'b0;
            r_errCount     <= '0;
            r_firstErrAddr <= '0;
        end else if (w_start) begin
            r_errFlag      <= 1'b0;
            r_errCount     <= '0;
            r_firstErrAddr <= '0;
        end else if (w_mismatch) begin
            r_errFlag <= 1'b1;
            if (r_errCount != 16'hFFFF) begin
                r_errCount <= r_errCount + 16'd1;
            end
            if (!r_errFlag) begin
                r_firstErrAddr <= r_pipeAddr[CHK_LAT-1];
            end
        end
    end

    assign CtrlOut      = r_ctrlOut;
    assign Busy         = r_busy;
    assign Done         = r_done;
    assign ErrFlag      = r_errFlag;
    assign ErrCount     = r_errCount;
    assign FirstErrAddr = r_firstErrAddr;

endmodule
`default_nettype wire

// File: tb/tb_dp_vector_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_dp_vector_player
// Description : Self-checking bench for dp_vector_player. A queue-based model
//               lists the issued entries of each run and derives CtrlOut,
//               Busy, Done and error status from them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dp_vector_player;

    localparam int CTRL_W  = 24;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 32;
    localparam int CHK_LAT = 1;
    localparam int ADDR_W  = $clog2(DEPTH);

    logic              Clock = 1'b0;
    logic              Reset;
    logic              LdEn;
    logic [ADDR_W-1:0] LdAddr;
    logic [CTRL_W-1:0] LdCtrl;
    logic [DATA_W-1:0] LdExp;
    logic              LdChk;
    logic              Start;
    logic              Stop;
    logic [ADDR_W-1:0] LastAddr;
    logic [7:0]        Loops;
    logic [DATA_W-1:0] Obs;
    logic [CTRL_W-1:0] CtrlOut;
    logic              Busy;
    logic              Done;
    logic              ErrFlag;
    logic [15:0]       ErrCount;
    logic [ADDR_W-1:0] FirstErrAddr;

    // Reference copy of the table
    logic [CTRL_W-1:0] mCtrl [DEPTH];
    logic [DATA_W-1:0] mExp  [DEPTH];
    logic              mChk  [DEPTH];

    int nChk  = 0;
    int nPass = 0;

    dp_vector_player #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CHK_LAT(CHK_LAT)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .LdEn        (LdEn),
        .LdAddr      (LdAddr),
        .LdCtrl      (LdCtrl),
        .LdExp       (LdExp),
        .LdChk       (LdChk),
        .Start       (Start),
        .Stop        (Stop),
        .LastAddr    (LastAddr),
        .Loops       (Loops),
        .Obs         (Obs),
        .CtrlOut     (CtrlOut),
        .Busy        (Busy),
        .Done        (Done),
        .ErrFlag     (ErrFlag),
        .ErrCount    (ErrCount),
        .FirstErrAddr(FirstErrAddr)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obsv, input logic [31:0] expv);
        nChk++;
        assert (obsv === expv) nPass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obsv, expv);
    endtask

    task automatic loadEntry(input int a, input logic [CTRL_W-1:0] c,
                             input logic [DATA_W-1:0] e, input logic k);
        @(negedge Clock);
        LdEn   = 1'b1;
        LdAddr = ADDR_W'(a);
        LdCtrl = c;
        LdExp  = e;
        LdChk  = k;
        @(posedge Clock); #1;
        LdEn = 1'b0;
        mCtrl[a] = c;
        mExp[a]  = e;
        mChk[a]  = k;
    endtask

    // badMode: 0 none, 1 only vector badIdx, 2 every vector, 3 random quarter
    task automatic play(input int lastA, input int loops, input int stopAt,
                        input int badMode, input int badIdx,
                        input bit stopAtStart, input bit cycleChk);
        int n;
        int span;
        int expErr;
        int firstA;
        int addrQ[$];
        logic [DATA_W-1:0] obsQ[$];
        logic [31:0] eCtrl;
        span   = lastA + 1;
        n      = (stopAt >= 0) ? stopAt + 1 : span * loops;
        expErr = 0;
        firstA = 0;
        for (int i = 0; i < n; i++) begin
            int a;
            bit b;
            a = i % span;
            case (badMode)
                1:       b = (i == badIdx);
                2:       b = 1'b1;
                3:       b = ($urandom_range(3) == 0);
                default: b = 1'b0;
            endcase
            addrQ.push_back(a);
            obsQ.push_back(b ? (mExp[a] ^ 16'($urandom_range(65535, 1))) : mExp[a]);
            if (b && mChk[a]) begin
                if (expErr == 0) firstA = a;
                expErr++;
            end
        end

        @(negedge Clock);
        Start    = 1'b1;
        Stop     = stopAtStart;
        LdEn     = 1'b0;
        LastAddr = ADDR_W'(lastA);
        Loops    = 8'(loops);
        Obs      = 16'($urandom);
        for (int t = 0; t <= n + CHK_LAT + 2; t++) begin
            int i;
            @(posedge Clock); #1;
            if (cycleChk) begin
                eCtrl = '0;
                if (t >= 1 && t <= n) eCtrl = 32'(mCtrl[addrQ[t-1]]);
                check($sformatf("ctrl t=%0d", t), 32'(CtrlOut), eCtrl);
                check($sformatf("busy t=%0d", t), 32'(Busy), 32'(t >= 1 && t <= n + CHK_LAT));
            end
            if (cycleChk || t == n + CHK_LAT + 1)
                check($sformatf("done t=%0d", t), 32'(Done), 32'(t == n + CHK_LAT + 1));
            // Inputs for edge t+1: noise that must be ignored outside IDLE
            Start = (t + 1 >= 2 && t + 1 <= n + CHK_LAT + 1) ? 1'($urandom_range(1)) : 1'b0;
            if (stopAt >= 0 && t + 1 == stopAt + 1)           Stop = 1'b1;
            else if (t + 1 > n && t + 1 <= n + CHK_LAT + 1)   Stop = 1'($urandom_range(1));
            else                                              Stop = 1'b0;
            LdEn     = (t + 1 <= n + CHK_LAT + 1) ? 1'($urandom_range(1)) : 1'b0;
            LdAddr   = ADDR_W'($urandom);
            LdCtrl   = CTRL_W'($urandom);
            LdExp    = 16'($urandom);
            LdChk    = 1'($urandom);
            LastAddr = ADDR_W'($urandom);
            Loops    = 8'($urandom);
            i = t - CHK_LAT;
            Obs = (i >= 0 && i < n) ? obsQ[i] : 16'($urandom);
        end
        Start = 1'b0;
        Stop  = 1'b0;
        LdEn  = 1'b0;
        check("errcount", 32'(ErrCount), (expErr > 65535) ? 32'hFFFF : 32'(expErr));
        check("errflag", 32'(ErrFlag), 32'(expErr > 0));
        check("firsterr", 32'(FirstErrAddr), 32'(firstA));
    endtask

    initial begin
        Reset = 1'b1; LdEn = 1'b0; LdAddr = '0; LdCtrl = '0; LdExp = '0; LdChk = 1'b0;
        Start = 1'b0; Stop = 1'b0; LastAddr = '0; Loops = '0; Obs = '0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst ctrl", 32'(CtrlOut), 32'h0);
        check("rst busy", 32'(Busy), 32'h0);
        check("rst done", 32'(Done), 32'h0);
        check("rst errflag", 32'(ErrFlag), 32'h0);
        check("rst errcount", 32'(ErrCount), 32'h0);
        check("rst firsterr", 32'(FirstErrAddr), 32'h0);
        Reset = 1'b0;

        // Directed table: ctrl 1..4, all checked
        for (int a = 0; a < 4; a++) loadEntry(a, CTRL_W'(a + 1), 16'($urandom), 1'b1);

        play(3, 1, -1, 0, 0, 1'b0, 1'b1);        // clean single pass
        play(3, 1, -1, 1, 2, 1'b0, 1'b1);        // entry 2 corrupted
        repeat (3) @(posedge Clock);
        #1;
        check("sticky errflag", 32'(ErrFlag), 32'h1);
        check("sticky errcount", 32'(ErrCount), 32'h1);
        play(1, 3, -1, 0, 0, 1'b0, 1'b1);        // three passes of two entries
        play(3, 0, 10, 0, 0, 1'b0, 1'b1);        // endless, stopped
        play(3, 1, -1, 3, 0, 1'b1, 1'b1);        // Start+Stop together: Start wins
        play(0, 2, -1, 2, 0, 1'b0, 1'b1);        // single-entry sequence

        // Reset mid-RUN with entry 2 active; LdEn during RUN must not write
        @(negedge Clock);
        Start = 1'b1; LastAddr = ADDR_W'(3); Loops = 8'd0; Obs = 16'($urandom);
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            LdEn   = (t == 1);
            LdAddr = ADDR_W'(1);
            LdCtrl = ~mCtrl[1];
            LdExp  = ~mExp[1];
            LdChk  = 1'b0;
            Obs    = (t >= 2) ? ~mExp[t-2] : 16'($urandom);
            @(posedge Clock); #1;
        end
        LdEn = 1'b0;
        check("midrun ctrl", 32'(CtrlOut), 32'(mCtrl[2]));
        check("midrun errcount", 32'(ErrCount), 32'd2);
        Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        check("midrst ctrl", 32'(CtrlOut), 32'h0);
        check("midrst busy", 32'(Busy), 32'h0);
        check("midrst errcount", 32'(ErrCount), 32'h0);
        check("midrst errflag", 32'(ErrFlag), 32'h0);
        check("midrst firsterr", 32'(FirstErrAddr), 32'h0);
        for (int t = 0; t < 3; t++) begin
            @(posedge Clock); #1;
            check("postrst done", 32'(Done), 32'h0);
            check("postrst ctrl", 32'(CtrlOut), 32'h0);
        end
        play(3, 1, -1, 0, 0, 1'b0, 1'b1);        // table intact after reset and LdEn

        // Randomized table and runs
        for (int a = 0; a < DEPTH; a++)
            loadEntry(a, CTRL_W'($urandom), 16'($urandom), 1'($urandom));
        for (int r = 0; r < 6; r++) begin
            if (r % 3 == 2)
                play($urandom_range(DEPTH - 1), 0, $urandom_range(60, 5), 3, 0, 1'b0, 1'b1);
            else
                play($urandom_range(DEPTH - 1), $urandom_range(3, 1), -1, 3, 0, 1'b0, 1'b1);
        end

        // Saturation: every entry checked, every vector wrong
        for (int a = 0; a < DEPTH; a++) loadEntry(a, CTRL_W'($urandom), 16'($urandom), 1'b1);
        play(DEPTH - 1, 0, 65540, 2, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
`default_nettype wire
